// File: rtl/instruction_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_fetch: PC register, program-memory addressing and IF/ID      |
// | register with stall, redirect, enable freeze and optional HALT detection |
// | (enabled by macro FETCH_HALT_DETECT_EN).                                 |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module instruction_fetch #(
  parameter int                 NB_ADDR   = 5,
  parameter int                 NB_DATA   = 32,
  parameter int                 ROM_DEPTH = 30,
  parameter logic [NB_DATA-1:0] HALT_CODE = '1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [NB_ADDR-1:0] i_branch_addr,
  input  logic [NB_DATA-1:0] i_instruction,
  output logic [NB_ADDR-1:0] o_read_addr,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_pc_next,
  output logic               o_valid,
  output logic               o_halt,
  output logic               o_addr_fault,
  output logic [15:0]        o_fetch_count
);

`ifdef FETCH_HALT_DETECT_EN
  localparam bit c_halt_detect = 1'b1;
`else
  localparam bit c_halt_detect = 1'b0;
`endif

  localparam logic [NB_ADDR-1:0] c_last_addr = NB_ADDR'(ROM_DEPTH - 1);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NB_ADDR-1:0]   pc_q, pc_d;
  logic [NB_DATA-1:0]   instr_q, instr_d;
  logic [NB_ADDR-1:0]   pc_next_q, pc_next_d;
  logic                 valid_q, valid_d;
  logic                 fault_q, fault_d;
  logic [15:0]          count_q, count_d;

  logic [NB_ADDR-1:0]   w_pc_plus1;
  logic                 w_addr_ok;
  logic                 w_is_halt;

  assign w_pc_plus1 = (pc_q == c_last_addr) ? '0 : pc_q + 1'b1;
  assign w_addr_ok  = (32'(i_branch_addr) < 32'(ROM_DEPTH));
  assign w_is_halt  = c_halt_detect && (i_instruction == HALT_CODE);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    fault_d   = 1'b0;
    count_d   = count_q;

    if (!i_enable) begin
      // frozen: nothing changes, fault pulse suppressed
    end else if (i_branch_taken) begin
      pc_d      = w_addr_ok ? i_branch_addr : '0;
      fault_d   = !w_addr_ok;
      instr_d   = '0;
      pc_next_d = '0;
      valid_d   = 1'b0;
      state_d   = RUN;
    end else if (i_stall) begin
      // hold PC, IF/ID and counter
    end else if (state_q == HALTED) begin
      instr_d   = '0;
      pc_next_d = '0;
      valid_d   = 1'b0;
    end else begin
      instr_d   = i_instruction;
      pc_next_d = w_pc_plus1;
      valid_d   = 1'b1;
      count_d   = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
      // A fetched HALT is still delivered downstream; only the PC parks on it.
      if (w_is_halt) begin
        state_d = HALTED;
      end else begin
        pc_d = w_pc_plus1;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= RUN;
      pc_q      <= '0;
      instr_q   <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      count_q   <= count_d;
    end
  end

  assign o_read_addr   = pc_q;
  assign o_instruction = instr_q;
  assign o_pc_next     = pc_next_q;
  assign o_valid       = valid_q;
  assign o_addr_fault  = fault_q;
  assign o_fetch_count = count_q;
  assign o_halt        = c_halt_detect ? (state_q == HALTED) : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instruction_fetch: directed table-driven bench for instruction_fetch. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_stall, i_branch_taken;
  logic [4:0]  i_branch_addr;
  logic [31:0] i_instruction;
  logic [4:0]  o_read_addr, o_pc_next;
  logic [31:0] o_instruction;
  logic        o_valid, o_halt, o_addr_fault;
  logic [15:0] o_fetch_count;

  logic [31:0] rom [32];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign i_instruction = rom[o_read_addr];

  instruction_fetch dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_stall        (i_stall),
    .i_branch_taken (i_branch_taken),
    .i_branch_addr  (i_branch_addr),
    .i_instruction  (i_instruction),
    .o_read_addr    (o_read_addr),
    .o_instruction  (o_instruction),
    .o_pc_next      (o_pc_next),
    .o_valid        (o_valid),
    .o_halt         (o_halt),
    .o_addr_fault   (o_addr_fault),
    .o_fetch_count  (o_fetch_count)
  );

  typedef struct {
    logic        en, st, br;
    logic [4:0]  ba;
    logic [4:0]  pc;
    logic [31:0] ins;
    logic [4:0]  pcn;
    logic        v, f;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [20];

  function automatic logic [31:0] word(input int n);
    return 32'h1000_0000 + 32'(n);
  endfunction

  function automatic vec_t mk(input logic en, st, br, input logic [4:0] ba, pc,
                              input logic [31:0] ins, input logic [4:0] pcn,
                              input logic v, f, input logic [15:0] cnt);
    vec_t r;
    r.en = en; r.st = st; r.br = br; r.ba = ba; r.pc = pc; r.ins = ins;
    r.pcn = pcn; r.v = v; r.f = f; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] pc, input logic [31:0] ins,
                         input logic [4:0] pcn, input logic v, f, h, input logic [15:0] cnt);
    chk({tag, ".pc"},    32'(o_read_addr),   32'(pc));
    chk({tag, ".ins"},   o_instruction,      ins);
    chk({tag, ".pcn"},   32'(o_pc_next),     32'(pcn));
    chk({tag, ".valid"}, 32'(o_valid),       32'(v));
    chk({tag, ".fault"}, 32'(o_addr_fault),  32'(f));
    chk({tag, ".halt"},  32'(o_halt),        32'(h));
    chk({tag, ".count"}, 32'(o_fetch_count), 32'(cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    i_reset = 1'b1;
    #1;
    chk_all("async_reset", 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = (i < 30) ? word(i) : 32'd0;
    i_reset = 1'b1; i_enable = 1'b1; i_stall = 1'b0;
    i_branch_taken = 1'b0; i_branch_addr = 5'd0;
    #2;
    chk_all("reset", 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    i_reset = 1'b0;

    // sequential fetch with one-cycle lag and wrap after 30 words
    for (int k = 1; k <= 30; k++) begin
      step();
      chk_all($sformatf("seq%0d", k), 5'(k % 30), word(k - 1), 5'(k % 30),
              1'b1, 1'b0, 1'b0, 16'(k));
    end

    //           en    st    br    ba     pc     ins       pcn    v     f     cnt
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 5'd0,  5'd1,  word(0),  5'd1,  1'b1, 1'b0, 16'd31);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 5'd0,  5'd2,  word(1),  5'd2,  1'b1, 1'b0, 16'd32);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 5'd0,  5'd3,  word(2),  5'd3,  1'b1, 1'b0, 16'd33);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 5'd0,  5'd4,  word(3),  5'd4,  1'b1, 1'b0, 16'd34);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 5'd0,  5'd5,  word(4),  5'd5,  1'b1, 1'b0, 16'd35);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 5'd0,  5'd5,  word(4),  5'd5,  1'b1, 1'b0, 16'd35);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 5'd0,  5'd5,  word(4),  5'd5,  1'b1, 1'b0, 16'd35);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 5'd0,  5'd5,  word(4),  5'd5,  1'b1, 1'b0, 16'd35);
    tbl[8]  = mk(1'b1, 1'b0, 1'b0, 5'd0,  5'd6,  word(5),  5'd6,  1'b1, 1'b0, 16'd36);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 5'd0,  5'd7,  word(6),  5'd7,  1'b1, 1'b0, 16'd37);
    tbl[10] = mk(1'b1, 1'b1, 1'b1, 5'd12, 5'd12, 32'd0,    5'd0,  1'b0, 1'b0, 16'd37);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 5'd0,  5'd13, word(12), 5'd13, 1'b1, 1'b0, 16'd38);
    tbl[12] = mk(1'b1, 1'b0, 1'b1, 5'd31, 5'd0,  32'd0,    5'd0,  1'b0, 1'b1, 16'd38);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 5'd0,  5'd1,  word(0),  5'd1,  1'b1, 1'b0, 16'd39);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 5'd0,  5'd1,  word(0),  5'd1,  1'b1, 1'b0, 16'd39);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 5'd31, 5'd1,  word(0),  5'd1,  1'b1, 1'b0, 16'd39);
    tbl[16] = mk(1'b1, 1'b0, 1'b0, 5'd0,  5'd2,  word(1),  5'd2,  1'b1, 1'b0, 16'd40);
    tbl[17] = mk(1'b1, 1'b0, 1'b1, 5'd29, 5'd29, 32'd0,    5'd0,  1'b0, 1'b0, 16'd40);
    tbl[18] = mk(1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  word(29), 5'd0,  1'b1, 1'b0, 16'd41);
    tbl[19] = mk(1'b1, 1'b0, 1'b1, 5'd30, 5'd0,  32'd0,    5'd0,  1'b0, 1'b1, 16'd41);

    for (int i = 0; i < 20; i++) begin
      i_enable = tbl[i].en; i_stall = tbl[i].st;
      i_branch_taken = tbl[i].br; i_branch_addr = tbl[i].ba;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].ins, tbl[i].pcn,
              tbl[i].v, tbl[i].f, 1'b0, tbl[i].cnt);
    end
    i_enable = 1'b1; i_stall = 1'b0; i_branch_taken = 1'b0; i_branch_addr = 5'd0;

    // asynchronous reset between edges, then restart from address 0
    do_reset();
    step();
    chk_all("post_reset", 5'd1, word(0), 5'd1, 1'b1, 1'b0, 1'b0, 16'd1);

    // HALT_CODE placed at address 4
    rom[4] = 32'hFFFF_FFFF;
    do_reset();
    for (int k = 1; k <= 4; k++) step();
    chk_all("pre_halt", 5'd4, word(3), 5'd4, 1'b1, 1'b0, 1'b0, 16'd4);
    step();
`ifdef FETCH_HALT_DETECT_EN
    chk_all("halt_cap", 5'd4, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0, 1'b1, 16'd5);
    step();
    chk_all("halt_hold1", 5'd4, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 16'd5);
    step();
    chk_all("halt_hold2", 5'd4, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 16'd5);
    i_branch_taken = 1'b1; i_branch_addr = 5'd2;
    step();
    i_branch_taken = 1'b0;
    chk_all("halt_exit", 5'd2, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd5);
    step();
    chk_all("halt_resume", 5'd3, word(2), 5'd3, 1'b1, 1'b0, 1'b0, 16'd6);
`else
    chk_all("halt_plain", 5'd5, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0, 1'b0, 16'd5);
    step();
    chk_all("halt_past", 5'd6, word(5), 5'd6, 1'b1, 1'b0, 1'b0, 16'd6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
